// File: rtl/pipeline_pkg.sv
// Shared pipeline sizing and types for the decode/execute hazard scoreboard.
package pipeline_pkg;

  localparam int unsigned NUM_REGISTERS           = 32;
  localparam int unsigned REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
  localparam int unsigned MAX_IN_FLIGHT           = 4;
  localparam int unsigned COUNT_WIDTH             = $clog2(MAX_IN_FLIGHT + 1);

  typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
  typedef logic [COUNT_WIDTH-1:0]             sb_count_t;

endpackage

// File: rtl/scoreboard_counter.sv
// Saturating up/down counter; simultaneous inc and dec cancel out.
module scoreboard_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned LIMIT = MAX_IN_FLIGHT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      dec,
  input  logic      clear,
  output sb_count_t count,
  output logic      nonzero,
  output logic      underflow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !dec && (count != sb_count_t'(LIMIT))) begin
      count <= count + sb_count_t'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - sb_count_t'(1);
    end
  end

  assign nonzero   = (count != '0);
  // A lone decrement of an empty counter is a retire nobody issued.
  assign underflow = dec && !inc && !clear && (count == '0);

endmodule

// File: rtl/register_scoreboard.sv
// In-order RAW/capacity hazard scoreboard between decode and execute,
// counting pending writes per register and in total.
module register_scoreboard
  import pipeline_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               decode_done,
  input  logic                               execute_stall,
  output logic                               hazard_stall,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] read_register_1_in,
  input  logic                               read_register_1_valid_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] read_register_2_in,
  input  logic                               read_register_2_valid_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  input  logic                               retire_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] retire_register,
  input  logic                               retire_register_valid,
  input  logic                               flush,
  output logic [NUM_REGISTERS-1:0]           busy_mask,
  output logic [COUNT_WIDTH-1:0]             in_flight_count,
  output logic                               scoreboard_empty,
  output logic                               underflow_error
);

  logic                     tracked_w;
  logic                     tracked_r;
  logic                     raw_hit;
  logic                     issue;
  logic                     inc_w;
  logic                     total_dec;
  logic                     total_nz;
  logic                     total_under;
  logic                     err;
  logic [NUM_REGISTERS-1:0] under_vec;
  sb_count_t                pend [NUM_REGISTERS];
  sb_count_t                total;

  assign tracked_w = write_register_valid_in && (write_register_in != '0);
  assign tracked_r = retire_valid && retire_register_valid && (retire_register != '0);

  assign raw_hit = (read_register_1_valid_in && (read_register_1_in != '0) &&
                    (pend[read_register_1_in] != '0)) ||
                   (read_register_2_valid_in && (read_register_2_in != '0) &&
                    (pend[read_register_2_in] != '0));

  assign hazard_stall = !rst_n ||
                        (decode_done && (raw_hit ||
                         (tracked_w && (total == sb_count_t'(MAX_IN_FLIGHT)))));

  assign issue = decode_done && !execute_stall && !hazard_stall && !flush;
  assign inc_w = issue && tracked_w;

  // Total only drops for a retire that actually cancels a pending write.
  assign total_dec = tracked_r &&
                     (busy_mask[retire_register] ||
                      (inc_w && (write_register_in == retire_register)));

  assign pend[0]      = '0;
  assign busy_mask[0] = 1'b0;
  assign under_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGISTERS; r++) begin : g_reg
    scoreboard_counter #(.LIMIT(MAX_IN_FLIGHT)) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_w && (write_register_in == reg_index_t'(r))),
      .dec       (tracked_r && (retire_register == reg_index_t'(r))),
      .clear     (flush),
      .count     (pend[r]),
      .nonzero   (busy_mask[r]),
      .underflow (under_vec[r])
    );
  end

  scoreboard_counter #(.LIMIT(MAX_IN_FLIGHT)) u_total (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (inc_w),
    .dec       (total_dec),
    .clear     (flush),
    .count     (total),
    .nonzero   (total_nz),
    .underflow (total_under)
  );

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((|under_vec) || total_under) begin
      err <= 1'b1;
    end
  end

  assign in_flight_count  = total;
  assign scoreboard_empty = !total_nz;
  assign underflow_error  = err;

endmodule
